// File: rtl/shake_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shake_pad_pkg
// Brief    : Shared constants and state type for the SHAKE block padder.
// Revision : 1.0 - initial release
// ============================================================================
package shake_pad_pkg;

    localparam int RATE128_WORDS = 21;
    localparam int RATE256_WORDS = 17;

    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END      = 8'h80;

    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        FULL   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shake_block_padder_if.sv
`default_nettype none
// ============================================================================
// Module   : shake_block_padder_if
// Brief    : Word-in / block-out handshake bundle of the SHAKE block padder.
// Revision : 1.0 - initial release
// ============================================================================
interface shake_block_padder_if #(
    parameter int W         = 64,
    parameter int MAX_WORDS = 21
);

    logic                   mode;
    logic [W-1:0]           in_data;
    logic                   in_valid;
    logic                   in_last;
    logic [2:0]             in_bytes;
    logic                   in_ready;
    logic [W*MAX_WORDS-1:0] out_block;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_ready;

    modport master (
        output mode, in_data, in_valid, in_last, in_bytes, out_ready,
        input  in_ready, out_block, out_valid, out_last
    );

    modport slave (
        input  mode, in_data, in_valid, in_last, in_bytes, out_ready,
        output in_ready, out_block, out_valid, out_last
    );

endinterface
`default_nettype wire

// File: rtl/shake_last_word.sv
`default_nettype none
// ============================================================================
// Module   : shake_last_word
// Brief    : Pads the final message word: keeps the valid bytes, places the
//            SHAKE domain byte right after them and zeroes the rest.
// Revision : 1.0 - initial release
// ============================================================================
module shake_last_word
    import shake_pad_pkg::*;
#(
    parameter int W = 64
) (
    input  wire  [W-1:0] i_data,
    input  wire  [2:0]   i_bytes,
    output logic [W-1:0] o_word
);

    for (genvar b = 0; b < W / 8; b++) begin : g_byte
        localparam logic [2:0] c_byte = 3'(b);
        assign o_word[8*b +: 8] = (c_byte < i_bytes)  ? i_data[8*b +: 8] :
                                  (c_byte == i_bytes) ? DOMAIN_SHAKE     : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/shake_block_padder.sv
`default_nettype none
// ============================================================================
// Module   : shake_block_padder
// Brief    : Collects 64-bit message words into one SHAKE-128/256 rate block,
//            pads the final block and hands blocks to the permutation.
// Revision : 1.0 - initial release
// ============================================================================
module shake_block_padder
    import shake_pad_pkg::*;
#(
    parameter int W         = 64,
    parameter int MAX_WORDS = 21
) (
    input  wire                   clk,
    input  wire                   rst_n,
    shake_block_padder_if.slave   bus
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [4:0]    r_cnt;
    logic          r_mode;
    logic          r_msg_start;
    logic          r_last;

    logic          w_mode;
    logic [4:0]    w_rate;
    logic [4:0]    w_rate_m1;
    logic [4:0]    w_cnt_inc;
    logic          w_accept;
    logic          w_block_done;
    logic          w_out_hs;
    logic [W-1:0]  w_padded;

    // Rate follows the live mode input only on the first word of a message.
    assign w_mode       = r_msg_start ? bus.mode : r_mode;
    assign w_rate       = w_mode ? 5'(RATE256_WORDS) : 5'(RATE128_WORDS);
    assign w_rate_m1    = w_rate - 5'd1;
    assign w_cnt_inc    = r_cnt + 5'd1;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_block_done = w_accept && (bus.in_last || (w_cnt_inc == w_rate));
    assign w_out_hs     = bus.out_valid && bus.out_ready;

    assign bus.in_ready  = rst_n && (r_state == ACCEPT);
    assign bus.out_valid = rst_n && (r_state == FULL);
    assign bus.out_last  = bus.out_valid && r_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCEPT:  if (w_block_done)  w_state_nxt = FULL;
            FULL:    if (bus.out_ready) w_state_nxt = ACCEPT;
            default: w_state_nxt = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= 5'd0;
            r_mode      <= 1'b0;
            r_msg_start <= 1'b1;
            r_last      <= 1'b0;
        end else if (w_accept) begin
            if (r_msg_start) begin
                r_mode <= bus.mode;
            end
            r_msg_start <= bus.in_last;
            r_last      <= bus.in_last;
            r_cnt       <= w_block_done ? 5'd0 : w_cnt_inc;
        end
    end

    shake_last_word #(
        .W (W)
    ) u_last_word (
        .i_data  (bus.in_data),
        .i_bytes (bus.in_bytes),
        .o_word  (w_padded)
    );

    // On the final word every slot above the counter is rewritten, which
    // zero-fills the tail and drops the 0x80 end marker into slot rate-1.
    for (genvar i = 0; i < MAX_WORDS; i++) begin : g_buf
        localparam logic [4:0] c_idx = 5'(i);
        logic [W-1:0] r_word;
        logic [W-1:0] w_end_mask;

        assign w_end_mask = (c_idx == w_rate_m1) ? {PAD_END, {(W-8){1'b0}}} : '0;

        always_ff @(posedge clk) begin
            if (!rst_n || w_out_hs) begin
                r_word <= '0;
            end else if (w_accept) begin
                if (c_idx == r_cnt) begin
                    r_word <= bus.in_last ? (w_padded | w_end_mask) : bus.in_data;
                end else if (bus.in_last && (c_idx > r_cnt)) begin
                    r_word <= w_end_mask;
                end
            end
        end

        assign bus.out_block[W*i +: W] = r_word;
    end

endmodule
`default_nettype wire
